bid_master: RTL and testbench
=============================

Name: bid_master

Overview:
- Initiator-side agent for one master port of the bidding arbiter.
- Accepts single-beat read/write commands from a local host, bids for the bus (req/xfr), and performs the transfer once granted.
- Mirrors the arbiter's per-master budget (bid credit) so it never bids more than it holds.
- Returns read data and status to the host.

Parameters:
- MASTER_ID, 0, master index 0-3; forms address bits [7:4].
- BID_W, 32, width of bid/budget values.
- MAX_AMOUNT, 100, budget reset and saturation value.
- BID_AMT, 5, replenish amount per interval.
- TIME_INTERVAL, 10, replenish every TIME_INTERVAL+1 cycles.
- XFER_CYCLES, 1, granted cycles per transfer (>=1).
- GRANT_TIMEOUT, 64, cycles in BID with no grant before abort.

Ports:
- clk  in  1  bus clock.
- rst_n  in  1  async active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_rw  in  1  1=write, 0=read (drives RW).
- cmd_slave  in  2  target slave index.
- cmd_wdata  in  32  write data.
- cmd_bid  in  BID_W  requested bid.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  with rsp_valid: 1=timeout abort.
- rsp_rdata  out  32  read data; valid with rsp_valid and !rsp_err.
- req  out  BID_W  bid to arbiter; 0 when idle.
- xfr  out  1  transfer request to arbiter.
- grant  in  1  arbiter grant.
- addr  out  32  slave address.
- RW  out  1  direction to arbiter.
- DataToSlave  out  32  write data.
- DataFromSlave  in  32  read data from arbiter.
- budget  out  BID_W  current mirrored budget (debug).

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; budget=MAX_AMOUNT; replenish cnt=0; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; req=0; xfr=0; addr=0; RW=0; DataToSlave=0. Reset mid-transfer abandons the transfer with no response.
- Address: addr = 32'hFFEF_0200 | (cmd_slave<<12) | (MASTER_ID<<4).
- Effective bid: eb = clamp(cmd_bid, 1, budget). Latched at command accept and re-clamped each cycle in BID if the budget falls.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, go to BID.
  - BID: xfr=1, req=eb, addr/RW/DataToSlave driven. On grant=1, go to XFER and debit the budget that same edge. If wait count reaches GRANT_TIMEOUT-1 without grant, go to DONE with err=1.
  - XFER: outputs held. Count granted cycles. At the edge ending cycle XFER_CYCLES, capture DataFromSlave and go to DONE. If grant=0 in any XFER cycle (preempted), return to BID with the count cleared; wait count restarts and there is no second debit until a new grant.
  - DONE: xfr=0, req=0. rsp_valid=1 for one cycle, then IDLE. cmd_ready=0 in BID/XFER/DONE.
- Budget arithmetic:
  - cnt increments each cycle and wraps to 0 at TIME_INTERVAL. At wrap, add BID_AMT, saturating at MAX_AMOUNT.
  - Debit: new = old - eb; if the result is <=0 or underflows, budget=1.
  - Replenish and debit in the same cycle: saturate first, then debit.
- Budget==1: eb=1. The arbiter excludes this master from bidding, so it is served only by its starvation guard. The block keeps xfr asserted; timeout still applies.
- All outputs are registered; grant is sampled only at clock edges.

Optional Feature:
- BID_ESCALATE_EN
  - Defined: in BID, every 8 cycles without grant, eb += 1, capped at budget. Resets to the latched cmd_bid on a new command.
  - Undefined: eb stays constant apart from budget clamping.

Decomposition:
- Shared package bid_pkg:
  - bm_state_t enum (IDLE, BID, XFER, DONE).
  - SLAVE_BASE = 32'hFFEF_0200, SLAVE_STRIDE = 32'h1000, MASTER_STRIDE = 32'h10.
  - Default MAX_AMOUNT/BID_AMT/TIME_INTERVAL constants shared with the arbiter.
- Sub-module bid_budget: replenish counter, saturation, debit and floor. Output budget; inputs debit_en and debit_amt.

Test Plan:
- Write, slave 2, MASTER_ID=1, cmd_bid=20, grant 2 cycles after xfr -> addr=FFEF2210, RW=1, budget 100->80, rsp_valid, rsp_err=0.
- Read, slave 0, DataFromSlave=DEADBEEF, XFER_CYCLES=1 -> rsp_rdata=DEADBEEF one cycle after grant edge; xfr drops in DONE.
- cmd_bid=150 with budget 30 -> req=30; after grant, budget=1; next command drives req=1.
- Never grant, GRANT_TIMEOUT=64 -> rsp_valid with rsp_err=1 exactly 64 cycles after entering BID; budget not debited.
- Budget 1, idle 11 cycles (TIME_INTERVAL=10) -> budget 6. At 98 with replenish and debit of 10 same cycle -> 90.
- rst_n low during XFER -> all outputs to reset values immediately; no rsp_valid; budget=100.

Source files
------------

// File: rtl/bid_pkg.sv
// Shared types and constants for the bidding-arbiter master agent and its arbiter.
package bid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BID  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } bm_state_t;

    localparam logic [31:0] SLAVE_BASE    = 32'hFFEF_0200;
    localparam logic [31:0] SLAVE_STRIDE  = 32'h0000_1000;
    localparam logic [31:0] MASTER_STRIDE = 32'h0000_0010;

    // Budget defaults must match the arbiter so the mirrored value tracks it.
    localparam int DEF_MAX_AMOUNT    = 100;
    localparam int DEF_BID_AMT       = 5;
    localparam int DEF_TIME_INTERVAL = 10;

endpackage

// File: rtl/bid_budget.sv
// Mirror of the arbiter's per-master bid credit: periodic replenish with
// saturation, debit on grant, and a floor of 1.
module bid_budget
    import bid_pkg::*;
#(
    parameter int BID_W         = 32,
    parameter int MAX_AMOUNT    = DEF_MAX_AMOUNT,
    parameter int BID_AMT       = DEF_BID_AMT,
    parameter int TIME_INTERVAL = DEF_TIME_INTERVAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debit_en,
    input  logic [BID_W-1:0] debit_amt,
    output logic [BID_W-1:0] budget
);

    localparam int CNT_W = (TIME_INTERVAL < 1) ? 1 : $clog2(TIME_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME_INTERVAL);
    localparam logic [BID_W:0]   MAX_EXT  = (BID_W+1)'(MAX_AMOUNT);
    localparam logic [BID_W:0]   AMT_EXT  = (BID_W+1)'(BID_AMT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BID_W-1:0] budget_q, budget_d;
    logic             wrap;
    logic [BID_W:0]   sum, sat, amt_ext, diff;

    assign wrap    = (cnt_q == CNT_LAST);
    assign amt_ext = {1'b0, debit_amt};

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sum   = {1'b0, budget_q} + (wrap ? AMT_EXT : '0);
        sat   = (sum > MAX_EXT) ? MAX_EXT : sum;
        diff  = sat - amt_ext;
        // Saturate first, then debit; a debit that would reach zero floors at 1.
        if (debit_en) begin
            budget_d = (amt_ext >= sat) ? BID_W'(1) : diff[BID_W-1:0];
        end else begin
            budget_d = sat[BID_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            budget_q <= BID_W'(MAX_AMOUNT);
        end else begin
            cnt_q    <= cnt_d;
            budget_q <= budget_d;
        end
    end

    assign budget = budget_q;

endmodule

// File: rtl/bid_master.sv
// Initiator agent for one arbiter master port: host command -> bid -> transfer -> response.
// Optional macro BID_ESCALATE_EN raises the bid by 1 every 8 ungranted BID cycles.
module bid_master
    import bid_pkg::*;
#(
    parameter int MASTER_ID     = 0,
    parameter int BID_W         = 32,
    parameter int MAX_AMOUNT    = DEF_MAX_AMOUNT,
    parameter int BID_AMT       = DEF_BID_AMT,
    parameter int TIME_INTERVAL = DEF_TIME_INTERVAL,
    parameter int XFER_CYCLES   = 1,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [1:0]       cmd_slave,
    input  logic [31:0]      cmd_wdata,
    input  logic [BID_W-1:0] cmd_bid,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_rdata,
    output logic [BID_W-1:0] req,
    output logic             xfr,
    input  logic             grant,
    output logic [31:0]      addr,
    output logic             RW,
    output logic [31:0]      DataToSlave,
    input  logic [31:0]      DataFromSlave,
    output logic [BID_W-1:0] budget
);

    localparam int WAIT_RAW = (GRANT_TIMEOUT < 2) ? 1 : $clog2(GRANT_TIMEOUT);
    localparam int WAIT_W   = (WAIT_RAW < 3) ? 3 : WAIT_RAW;
    localparam int XC_W     = (XFER_CYCLES < 2) ? 1 : $clog2(XFER_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GRANT_TIMEOUT - 1);
    localparam logic [XC_W-1:0]   XC_LAST   = XC_W'(XFER_CYCLES - 1);
    localparam logic [31:0]       MASTER_OFS = 32'(MASTER_ID) * MASTER_STRIDE;

    bm_state_t         state_q, state_d;
    logic [BID_W-1:0]  eb_q, eb_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XC_W-1:0]   xcnt_q, xcnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [BID_W-1:0]  req_q, req_d;
    logic              xfr_q, xfr_d;
    logic [31:0]       addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              debit_en;
    logic              esc_step;
    logic [BID_W-1:0]  eb_grow;

    function automatic logic [BID_W-1:0] min_bid(input logic [BID_W-1:0] a,
                                                 input logic [BID_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [BID_W-1:0] clamp_bid(input logic [BID_W-1:0] bid,
                                                   input logic [BID_W-1:0] limit);
        logic [BID_W-1:0] lo;
        lo = (bid == '0) ? BID_W'(1) : bid;
        return min_bid(lo, limit);
    endfunction

    function automatic logic [31:0] slave_addr(input logic [1:0] slv);
        return SLAVE_BASE | ({30'd0, slv} * SLAVE_STRIDE) | MASTER_OFS;
    endfunction

`ifdef BID_ESCALATE_EN
    assign esc_step = (wait_q[2:0] == 3'b111);
`else
    assign esc_step = 1'b0;
`endif

    assign eb_grow  = eb_q + (esc_step ? BID_W'(1) : '0);
    // The debit uses the bid the arbiter saw on req when it granted.
    assign debit_en = (state_q == BID) && grant;

    bid_budget #(
        .BID_W         (BID_W),
        .MAX_AMOUNT    (MAX_AMOUNT),
        .BID_AMT       (BID_AMT),
        .TIME_INTERVAL (TIME_INTERVAL)
    ) u_budget (
        .clk       (clk),
        .rst_n     (rst_n),
        .debit_en  (debit_en),
        .debit_amt (eb_q),
        .budget    (budget)
    );

    always_comb begin
        state_d     = state_q;
        eb_d        = eb_q;
        wait_d      = wait_q;
        xcnt_d      = xcnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        req_d       = req_q;
        xfr_d       = xfr_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    eb_d        = clamp_bid(cmd_bid, budget);
                    req_d       = eb_d;
                    xfr_d       = 1'b1;
                    addr_d      = slave_addr(cmd_slave);
                    rw_d        = cmd_rw;
                    wdata_d     = cmd_wdata;
                    wait_d      = '0;
                    xcnt_d      = '0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = BID;
                end
            end
            BID: begin
                if (grant) begin
                    xcnt_d  = '0;
                    state_d = XFER;
                end else if (wait_q == WAIT_LAST) begin
                    xfr_d       = 1'b0;
                    req_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    eb_d   = min_bid(eb_grow, budget);
                    req_d  = eb_d;
                end
            end
            XFER: begin
                if (!grant) begin
                    // Preempted: bid again from a fresh wait window.
                    wait_d  = '0;
                    xcnt_d  = '0;
                    eb_d    = min_bid(eb_q, budget);
                    req_d   = eb_d;
                    state_d = BID;
                end else if (xcnt_q == XC_LAST) begin
                    rsp_rdata_d = DataFromSlave;
                    xfr_d       = 1'b0;
                    req_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = DONE;
                end else begin
                    xcnt_d = xcnt_q + 1'b1;
                end
            end
            DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                xfr_d       = 1'b0;
                req_d       = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            eb_q        <= '0;
            wait_q      <= '0;
            xcnt_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_q       <= '0;
            xfr_q       <= 1'b0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            eb_q        <= eb_d;
            wait_q      <= wait_d;
            xcnt_q      <= xcnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_q       <= req_d;
            xfr_q       <= xfr_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign req         = req_q;
    assign xfr         = xfr_q;
    assign addr        = addr_q;
    assign RW          = rw_q;
    assign DataToSlave = wdata_q;

endmodule

// File: tb/tb_bid_master.sv
// Randomized bench for bid_master against a transaction-timeline budget model.
module tb_bid_master;

    localparam int          MID  = 1;
    localparam logic [31:0] MAXA = 32'd100;
    localparam logic [31:0] BA   = 32'd5;
    localparam int          TI   = 10;
    localparam int          XC   = 1;
    localparam int          TO   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [1:0]  cmd_slave = 2'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [31:0] cmd_bid = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] req;
    logic        xfr;
    logic        grant = 1'b0;
    logic [31:0] addr;
    logic        RW;
    logic [31:0] DataToSlave;
    logic [31:0] DataFromSlave = 32'd0;
    logic [31:0] budget;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_txn  = 0;
    logic [31:0] m_budget = MAXA;
    int          m_cnt    = 0;

    always #5 clk = ~clk;

    bid_master #(
        .MASTER_ID     (MID),
        .BID_W         (32),
        .MAX_AMOUNT    (100),
        .BID_AMT       (5),
        .TIME_INTERVAL (TI),
        .XFER_CYCLES   (XC),
        .GRANT_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_slave     (cmd_slave),
        .cmd_wdata     (cmd_wdata),
        .cmd_bid       (cmd_bid),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .req           (req),
        .xfr           (xfr),
        .grant         (grant),
        .addr          (addr),
        .RW            (RW),
        .DataToSlave   (DataToSlave),
        .DataFromSlave (DataFromSlave),
        .budget        (budget)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    // One clock edge: advance the budget model by the rules, then sample.
    task automatic tick(input bit dbt, input logic [31:0] amt);
        logic [31:0] sat;
        @(posedge clk);
        sat = m_budget + ((m_cnt == TI) ? BA : 32'd0);
        if (sat > MAXA) sat = MAXA;
        m_cnt = (m_cnt == TI) ? 0 : m_cnt + 1;
        if (dbt) m_budget = (amt >= sat) ? 32'd1 : sat - amt;
        else     m_budget = sat;
        #1;
        chk_eq("budget", budget, m_budget);
    endtask

    task automatic run_txn(input bit rw, input logic [1:0] slv, input logic [31:0] wd,
                           input logic [31:0] bid, input int gdly, input bit pre,
                           input int gdly2, input bit tmo, input logic [31:0] rd);
        logic [31:0] eb;
        logic [31:0] ea;
        chk_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_slave = slv;
        cmd_wdata = wd;
        cmd_bid   = bid;
        eb = umin((bid == 32'd0) ? 32'd1 : bid, m_budget);
        ea = 32'hFFEF_0200 | ({30'd0, slv} << 12) | (32'(MID) << 4);
        tick(1'b0, 32'd0);
        cmd_valid = 1'b0;
        cmd_bid   = $urandom;
        chk_eq("req_bid", req, eb);
        chk_eq("xfr_bid", {31'd0, xfr}, 32'd1);
        chk_eq("addr", addr, ea);
        chk_eq("rw", {31'd0, RW}, {31'd0, rw});
        chk_eq("wdata", DataToSlave, wd);
        chk_eq("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        if (tmo) begin
            for (int i = 0; i < TO - 1; i++) begin
                eb = umin(eb, m_budget);
                tick(1'b0, 32'd0);
            end
            chk_eq("no_early_rsp", {31'd0, rsp_valid}, 32'd0);
            chk_eq("req_late", req, eb);
            tick(1'b0, 32'd0);
            chk_eq("tmo_valid", {31'd0, rsp_valid}, 32'd1);
            chk_eq("tmo_err", {31'd0, rsp_err}, 32'd1);
            chk_eq("tmo_xfr", {31'd0, xfr}, 32'd0);
            chk_eq("tmo_req", req, 32'd0);
        end else begin
            for (int i = 0; i < gdly; i++) begin
                eb = umin(eb, m_budget);
                tick(1'b0, 32'd0);
            end
            grant = 1'b1;
            tick(1'b1, eb);
            chk_eq("xfr_xfer", {31'd0, xfr}, 32'd1);
            chk_eq("req_xfer", req, eb);
            if (pre) begin
                grant = 1'b0;
                eb = umin(eb, m_budget);
                tick(1'b0, 32'd0);
                chk_eq("req_rebid", req, eb);
                chk_eq("xfr_rebid", {31'd0, xfr}, 32'd1);
                for (int i = 0; i < gdly2; i++) begin
                    eb = umin(eb, m_budget);
                    tick(1'b0, 32'd0);
                end
                grant = 1'b1;
                tick(1'b1, eb);
            end
            DataFromSlave = rd;
            for (int i = 0; i < XC; i++) tick(1'b0, 32'd0);
            grant = 1'b0;
            DataFromSlave = $urandom;
            chk_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk_eq("rsp_err", {31'd0, rsp_err}, 32'd0);
            chk_eq("done_xfr", {31'd0, xfr}, 32'd0);
            chk_eq("done_req", req, 32'd0);
            if (!rw) chk_eq("rdata", rsp_rdata, rd);
        end
        tick(1'b0, 32'd0);
        chk_eq("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        n_txn++;
        $display("txn %0d rw=%0d slave=%0d bid=%0d eb=%0d gdly=%0d pre=%0d tmo=%0d budget=%0d",
                 n_txn, rw, slv, bid, eb, gdly, pre, tmo, m_budget);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_eq("rst_budget", budget, 32'd100);
        chk_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk_eq("rst_xfr", {31'd0, xfr}, 32'd0);
        chk_eq("rst_req", req, 32'd0);
        chk_eq("rst_addr", addr, 32'd0);
        chk_eq("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_budget = MAXA;
        m_cnt    = 0;

        run_txn(1'b1, 2'd2, 32'hCAFE_0001, 32'd20, 2, 1'b0, 0, 1'b0, 32'd0);
        run_txn(1'b0, 2'd0, 32'd0, 32'd10, 0, 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
        run_txn(1'b1, 2'd1, 32'h1234_5678, 32'd40, 1, 1'b0, 0, 1'b0, 32'd0);
        run_txn(1'b1, 2'd3, 32'h0000_00AA, 32'd150, 0, 1'b0, 0, 1'b0, 32'd0);
        run_txn(1'b0, 2'd3, 32'd0, 32'd150, 0, 1'b0, 0, 1'b0, 32'h0BAD_F00D);
        run_txn(1'b0, 2'd1, 32'd0, 32'd0, 0, 1'b1, 0, 1'b1, 32'd0);
        idle(11);
        run_txn(1'b1, 2'd2, 32'h5555_AAAA, 32'd30, 1, 1'b1, 3, 1'b0, 32'd0);

        // Reset in the middle of a transfer: everything returns to reset values.
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_slave = 2'd1;
        cmd_bid   = 32'd7;
        tick(1'b0, 32'd0);
        cmd_valid = 1'b0;
        grant = 1'b1;
        tick(1'b1, umin(32'd7, m_budget));
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_xfr", {31'd0, xfr}, 32'd0);
        chk_eq("mid_rst_req", req, 32'd0);
        chk_eq("mid_rst_budget", budget, 32'd100);
        chk_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk_eq("mid_rst_addr", addr, 32'd0);
        chk_eq("mid_rst_rw", {31'd0, RW}, 32'd0);
        chk_eq("mid_rst_wdata", DataToSlave, 32'd0);
        chk_eq("mid_rst_rdata", rsp_rdata, 32'd0);
        grant = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_budget = MAXA;
        m_cnt    = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'd0);
            chk_eq("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        for (int t = 0; t < 40; t++) begin
            logic [31:0] bid;
            bid = ($urandom_range(0, 7) == 0) ? 32'd200 : 32'($urandom_range(0, 40));
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, bid,
                    $urandom_range(0, 10), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 6), ($urandom_range(0, 9) == 0), $urandom);
            idle($urandom_range(0, 14));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
